// File: rtl/seq_divider_hhrb98_if.sv
// Start/busy/done handshake and operand/result bus between the tile top and the divider.
// check_err is present only when SEQDIV_SELFCHECK_EN is defined.
interface seq_divider_hhrb98_if #(
  parameter int N_W = 8,
  parameter int D_W = 4
);
  logic           start;
  logic [N_W-1:0] dividend;
  logic [D_W-1:0] divisor;
  logic           busy;
  logic           done;
  logic [N_W-1:0] quotient;
  logic [D_W-1:0] remainder;
  logic           div_by_zero;
`ifdef SEQDIV_SELFCHECK_EN
  logic           check_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, check_err
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, check_err
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif
endinterface

// File: rtl/seq_divider_hhrb98.sv
// Restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional SEQDIV_SELFCHECK_EN adds a q*d+r result checker driving check_err.
module seq_divider_hhrb98 #(
  parameter int N_W = 8,
  parameter int D_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_hhrb98_if.slave bus
);
  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [N_W-1:0] r_dvd;
  logic [D_W-1:0] r_dvs;
  logic [D_W-1:0] r_rem;
  logic [N_W-1:0] r_quot;
  logic [D_W-1:0] r_remo;
  logic           r_dbz;

  logic           w_accept;
  logic           w_last;
  logic [D_W:0]   w_shift;
  logic [D_W:0]   w_diff;
  logic           w_qbit;
  logic [N_W-1:0] w_q_nxt;
  logic [D_W-1:0] w_rem_nxt;
  logic           w_busy;
  logic           w_done;

  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CNT_W'(N_W - 1));

  // r_dvd doubles as the quotient register: dividend bits leave at the MSB
  // while quotient bits enter at the LSB.
  assign w_shift   = {r_rem, r_dvd[N_W-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_diff[D_W];
  assign w_rem_nxt = w_qbit ? w_diff[D_W-1:0] : w_shift[D_W-1:0];
  assign w_q_nxt   = {r_dvd[N_W-2:0], w_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = (bus.divisor == '0) ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= bus.dividend;
      r_dvs <= bus.divisor;
      r_rem <= '0;
      r_cnt <= '0;
      if (bus.divisor == '0) begin
        r_quot <= '1;
        r_remo <= bus.dividend[D_W-1:0];
        r_dbz  <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_dvd <= w_q_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_quot <= w_q_nxt;
        r_remo <= w_rem_nxt;
        r_dbz  <= 1'b0;
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remo;
  assign bus.div_by_zero = r_dbz;

`ifdef SEQDIV_SELFCHECK_EN
  localparam int M_W = N_W + D_W;

  logic [N_W-1:0] r_dvd_cap;
  logic           r_chk;
  logic [M_W-1:0] w_mac;
  logic           w_chk_nxt;

  assign w_mac     = M_W'(w_q_nxt) * M_W'(r_dvs) + M_W'(w_rem_nxt);
  assign w_chk_nxt = (w_mac != M_W'(r_dvd_cap)) || (w_rem_nxt >= r_dvs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd_cap <= '0;
      r_chk     <= 1'b0;
    end else if (w_accept) begin
      r_dvd_cap <= bus.dividend;
      if (bus.divisor == '0) begin
        r_chk <= 1'b0;
      end
    end else if ((r_state == S_RUN) && w_last) begin
      r_chk <= w_chk_nxt;
    end
  end

  assign bus.check_err = r_chk;
`endif
endmodule

// File: tb/tb_seq_divider_hhrb98.sv
// Directed and exhaustive checks of seq_divider_hhrb98 (latency, handshake, results, reset).
module tb_seq_divider_hhrb98;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] last_q;
  logic [3:0] last_r;
  logic       last_dbz;

  always #5 clk = ~clk;

  seq_divider_hhrb98_if #(.N_W(8), .D_W(4)) u_if ();

  seq_divider_hhrb98 #(.N_W(8), .D_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    u_if.start = 1'b0;
    u_if.dividend = '0;
    u_if.divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_vec++; if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", u_if.busy); end
    n_vec++; if (u_if.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", u_if.done); end
    n_vec++; if (u_if.quotient !== 8'd0) begin n_err++; $display("FAIL reset_q got %0d want 0", u_if.quotient); end
    n_vec++; if (u_if.remainder !== 4'd0) begin n_err++; $display("FAIL reset_r got %0d want 0", u_if.remainder); end
    n_vec++; if (u_if.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", u_if.div_by_zero); end
    last_q = 8'd0; last_r = 4'd0; last_dbz = 1'b0;
  endtask

  task automatic test_div(input string name, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic edbz);
    int done_edge, done_cnt, busy_cnt, exp_edge, exp_busy;
    done_edge = 0; done_cnt = 0; busy_cnt = 0;
    exp_edge = edbz ? 1 : 9;
    exp_busy = edbz ? 0 : 8;
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.dividend = a; u_if.divisor = b;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      u_if.start = 1'b0;
      u_if.dividend = 8'($urandom);
      u_if.divisor = 4'($urandom);
      if (u_if.busy) busy_cnt++;
      if (u_if.done) begin
        done_cnt++;
        if (done_edge == 0) done_edge = e;
      end
      if (e == 1 && !edbz) begin
        n_vec++;
        if (u_if.quotient !== last_q || u_if.remainder !== last_r || u_if.div_by_zero !== last_dbz) begin
          n_err++;
          $display("FAIL %s_hold got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", name,
                   u_if.quotient, u_if.remainder, u_if.div_by_zero, last_q, last_r, last_dbz);
        end
      end
    end
    n_vec++; if (done_edge != exp_edge) begin n_err++; $display("FAIL %s_latency got %0d want %0d", name, done_edge, exp_edge); end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL %s_done_pulses got %0d want 1", name, done_cnt); end
    n_vec++; if (busy_cnt != exp_busy) begin n_err++; $display("FAIL %s_busy_cycles got %0d want %0d", name, busy_cnt, exp_busy); end
    n_vec++; if (u_if.quotient !== eq) begin n_err++; $display("FAIL %s_q got %0d want %0d", name, u_if.quotient, eq); end
    n_vec++; if (u_if.remainder !== er) begin n_err++; $display("FAIL %s_r got %0d want %0d", name, u_if.remainder, er); end
    n_vec++; if (u_if.div_by_zero !== edbz) begin n_err++; $display("FAIL %s_dbz got %b want %b", name, u_if.div_by_zero, edbz); end
`ifdef SEQDIV_SELFCHECK_EN
    n_vec++; if (u_if.check_err !== 1'b0) begin n_err++; $display("FAIL %s_check_err got %b want 0", name, u_if.check_err); end
`endif
    last_q = eq; last_r = er; last_dbz = edbz;
  endtask

  task automatic test_back_to_back;
    int de;
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.dividend = 8'd200; u_if.divisor = 4'd7;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_vec++; if (u_if.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_mid got %b want 1", u_if.busy); end
    u_if.start = 1'b1; u_if.dividend = 8'd13; u_if.divisor = 4'd2;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    de = 0;
    for (int e = 5; e <= 14 && de == 0; e++) begin
      @(posedge clk); #1;
      if (u_if.done) de = e;
    end
    n_vec++; if (de != 9) begin n_err++; $display("FAIL b2b_first_latency got %0d want 9", de); end
    n_vec++; if (u_if.quotient !== 8'd28 || u_if.remainder !== 4'd4) begin
      n_err++; $display("FAIL b2b_first_result got q=%0d r=%0d want q=28 r=4", u_if.quotient, u_if.remainder);
    end
    u_if.start = 1'b1; u_if.dividend = 8'd13; u_if.divisor = 4'd2;
    de = 0;
    for (int e = 1; e <= 12 && de == 0; e++) begin
      @(posedge clk); #1;
      u_if.start = 1'b0;
      if (e == 1) begin
        n_vec++; if (u_if.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_in_done got busy=%b want 1", u_if.busy); end
      end
      if (u_if.done) de = e;
    end
    n_vec++; if (de != 9) begin n_err++; $display("FAIL b2b_second_latency got %0d want 9", de); end
    n_vec++; if (u_if.quotient !== 8'd6 || u_if.remainder !== 4'd1) begin
      n_err++; $display("FAIL b2b_second_result got q=%0d r=%0d want q=6 r=1", u_if.quotient, u_if.remainder);
    end
    last_q = 8'd6; last_r = 4'd1; last_dbz = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int done_cnt;
    done_cnt = 0;
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.dividend = 8'd200; u_if.divisor = 4'd7;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      u_if.start = 1'b0;
    end
    n_vec++; if (u_if.busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before got %b want 1", u_if.busy); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (u_if.busy !== 1'b0 || u_if.done !== 1'b0) begin
      n_err++; $display("FAIL rstmid_ctrl got busy=%b done=%b want 0 0", u_if.busy, u_if.done);
    end
    n_vec++; if (u_if.quotient !== 8'd0 || u_if.remainder !== 4'd0 || u_if.div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL rstmid_results got q=%0d r=%0d z=%b want 0 0 0", u_if.quotient, u_if.remainder, u_if.div_by_zero);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (u_if.done) done_cnt++;
    end
    n_vec++; if (done_cnt != 0) begin n_err++; $display("FAIL rstmid_no_done got %0d pulses want 0", done_cnt); end
    last_q = 8'd0; last_r = 4'd0; last_dbz = 1'b0;
    test_div("after_rst_9_3", 8'd9, 4'd3, 8'd3, 4'd0, 1'b0);
  endtask

  task automatic test_sweep;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ed;
    logic       seen;
    int         prints;
    prints = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        ed = (b == 0);
        eq = ed ? 8'hFF : 8'(a / b);
        er = ed ? 4'(a) : 4'(a % b);
        @(posedge clk); #1;
        u_if.start = 1'b1; u_if.dividend = 8'(a); u_if.divisor = 4'(b);
        seen = 1'b0;
        for (int e = 1; e <= 12 && !seen; e++) begin
          @(posedge clk); #1;
          u_if.start = 1'b0;
          if (u_if.done) seen = 1'b1;
        end
        n_vec++;
        if (!seen || u_if.quotient !== eq || u_if.remainder !== er || u_if.div_by_zero !== ed
`ifdef SEQDIV_SELFCHECK_EN
            || u_if.check_err !== 1'b0
`endif
           ) begin
          n_err++;
          if (prints < 10) begin
            prints++;
            $display("FAIL sweep_%0d_%0d got done=%b q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                     a, b, seen, u_if.quotient, u_if.remainder, u_if.div_by_zero, eq, er, ed);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_div("200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    test_div("255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
    test_div("5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
    test_div("0_1", 8'd0, 4'd1, 8'd0, 4'd0, 1'b0);
    test_div("100_0", 8'd100, 4'd0, 8'd255, 4'd4, 1'b1);
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
